uart_rx: RTL and testbench

Serial receiver for the 8N1 line produced by the codebase's transmitters, which idle high and send a start bit, 8 data bits LSB first, and a stop bit. It consumes the `tx` line of an upstream transmitter and returns each received byte on a parallel bus with a one-cycle strobe. It also detects bad stop bits. Bit timing comes from an internal counter of the same divisor constant the transmitters use, so both ends share one baud definition.

---
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Parallel side of the 8N1 receiver: serial input plus the byte/strobe/status outputs.
// master is the receiver itself, slave is whatever drives rx and consumes bytes.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       ferr;
  logic       busy;

  modport master (input rx, output data, rcv, ferr, busy);
  modport slave  (output rx, input data, rcv, ferr, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a mid-bit sampling baud counter and stop-bit framing check.
//   state   | meaning
//   S_WAIT  | after reset or break: wait for the line to go high
//   S_IDLE  | line high, looking for a start edge
//   S_START | counting to mid start bit, rejecting glitches
//   S_DATA  | sampling 8 data bits, LSB first
//   S_STOP  | sampling the stop bit, publishing byte or flagging ferr
module uart_rx #(
  parameter int M = 104
) (
  input logic        clk,
  input logic        rstn,
  uart_rx_if.master  bus
);

  localparam int H  = M >> 1;
  localparam int CW = $clog2(M);

  typedef enum logic [2:0] {
    S_WAIT,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_s1, r_rx_s;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_nb, w_nb_nxt;
  logic [7:0]      r_sh, w_sh_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic            r_rcv, w_rcv_nxt;
  logic            r_ferr, w_ferr_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1   <= 1'b0;
      r_rx_s <= 1'b0;
    end else begin
      r_s1   <= bus.rx;
      r_rx_s <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
      r_nb    <= 3'd0;
      r_sh    <= 8'h00;
      r_data  <= 8'h00;
      r_rcv   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_nb    <= w_nb_nxt;
      r_sh    <= w_sh_nxt;
      r_data  <= w_data_nxt;
      r_rcv   <= w_rcv_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // cnt defaults to clear, so every transition and every bit sample restarts it
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_nb_nxt    = r_nb;
    w_sh_nxt    = r_sh;
    w_data_nxt  = r_data;
    w_rcv_nxt   = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (!r_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == CW'(H - 1)) begin
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_nb_nxt    = 3'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == CW'(M - 1)) begin
          w_sh_nxt = {r_rx_s, r_sh[7:1]};
          if (r_nb == 3'd7) w_state_nxt = S_STOP;
          else              w_nb_nxt    = r_nb + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == CW'(M - 1)) begin
          if (r_rx_s) begin
            w_data_nxt  = r_sh;
            w_rcv_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            // a low stop bit may be a break; wait for the line to recover
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_WAIT;
      end
    endcase
  end

  assign bus.data = r_data;
  assign bus.rcv  = r_rcv;
  assign bus.ferr = r_ferr;
  assign bus.busy = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized 8N1 frames against an M=16 receiver plus a default-M instance
// fed by a periodic "C" transmitter; expected timing comes from the frame edge formula.
module tb_uart_rx;

  localparam int MS  = 16;
  localparam int HS  = MS >> 1;
  localparam int MD  = 104;
  localparam int LAT = 1 + 2 + HS + 9 * MS;

  typedef struct { int cyc; logic [7:0] d; } rev_t;
  typedef struct { int cyc; logic b; } bev_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_rx_if bus16 ();
  uart_rx_if bus104 ();

  uart_rx #(.M(MS)) u_dut16  (.clk(clk), .rstn(rstn), .bus(bus16));
  uart_rx           u_dut104 (.clk(clk), .rstn(rstn), .bus(bus104));

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  rev_t rcv_q[$];
  int   ferr_q[$];
  bev_t busy_q[$];
  logic prev_busy = 1'b0;
  logic prev_pulse = 1'b0;
  int   bad_pulse = 0;
  int   n104 = 0, bad104 = 0, f104 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus16.rcv === 1'b1) rcv_q.push_back('{cyc, bus16.data});
    if (bus16.ferr === 1'b1) ferr_q.push_back(cyc);
    if (bus16.busy !== prev_busy) begin
      busy_q.push_back('{cyc, bus16.busy});
      prev_busy = bus16.busy;
    end
    if ((bus16.rcv && bus16.ferr) || ((bus16.rcv || bus16.ferr) && prev_pulse)) bad_pulse++;
    prev_pulse = bus16.rcv || bus16.ferr;
    if (bus104.rcv === 1'b1) begin
      n104++;
      if (bus104.data !== 8'h43) bad104++;
    end
    if (bus104.ferr === 1'b1) f104++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    rcv_q.delete();
    ferr_q.delete();
    busy_q.delete();
  endtask

  task automatic bit16(input logic v);
    bus16.rx = v;
    tick(MS);
  endtask

  task automatic send16(input logic [7:0] b, input logic stopv, output int t0);
    t0 = cyc;
    bit16(1'b0);
    for (int i = 0; i < 8; i++) bit16(b[i]);
    bit16(stopv);
  endtask

  task automatic send104(input logic [7:0] b);
    bus104.rx = 1'b0;
    tick(MD);
    for (int i = 0; i < 8; i++) begin
      bus104.rx = b[i];
      tick(MD);
    end
    bus104.rx = 1'b1;
    tick(MD);
  endtask

  // single good frame: one rcv at the formula edge carrying the byte, no ferr
  task automatic expect_one(input string tag, input int t0, input logic [7:0] b);
    chk({tag, "_rcv_n"}, rcv_q.size(), 1);
    chk({tag, "_ferr_n"}, ferr_q.size(), 0);
    if (rcv_q.size() >= 1) begin
      chk({tag, "_rcv_cyc"}, rcv_q[0].cyc, t0 + LAT);
      chk({tag, "_data"}, rcv_q[0].d, b);
    end
  endtask

  initial begin
    int t0, ta, tb;
    logic [7:0] b;
    rev_t exp_q[$];

    bus16.rx  = 1'b1;
    bus104.rx = 1'b1;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    tick(3);
    chk("rst_data", bus16.data, 8'h00);
    chk("rst_rcv",  bus16.rcv,  1'b0);
    chk("rst_ferr", bus16.ferr, 1'b0);
    chk("rst_busy", bus16.busy, 1'b0);
    rstn = 1'b1;
    tick(5);
    clear_q();

    // bad stop bit then a long break
    send16(8'h7E, 1'b0, t0);
    tick(40);
    chk("brk_ferr_n", ferr_q.size(), 1);
    if (ferr_q.size() >= 1) chk("brk_ferr_cyc", ferr_q[0], t0 + LAT);
    chk("brk_rcv_n", rcv_q.size(), 0);
    chk("brk_data", bus16.data, 8'h00);
    chk("brk_busy_n", busy_q.size(), 2);
    if (busy_q.size() >= 2) chk("brk_busy_fall", busy_q[1].cyc, t0 + LAT);
    bus16.rx = 1'b1;
    tick(5);

    clear_q();
    send16(8'h43, 1'b1, t0);
    tick(5);
    expect_one("c43", t0, 8'h43);
    chk("c43_busy_n", busy_q.size(), 2);
    if (busy_q.size() >= 2) begin
      chk("c43_busy_rise", busy_q[0].cyc, t0 + 3);
      chk("c43_busy_fall", busy_q[1].cyc, t0 + LAT);
    end

    clear_q();
    send16(8'h55, 1'b1, ta);
    send16(8'hA3, 1'b1, tb);
    tick(5);
    chk("b2b_rcv_n", rcv_q.size(), 2);
    chk("b2b_ferr_n", ferr_q.size(), 0);
    if (rcv_q.size() >= 2) begin
      chk("b2b_cyc0", rcv_q[0].cyc, ta + LAT);
      chk("b2b_gap", rcv_q[1].cyc - rcv_q[0].cyc, 10 * MS);
      chk("b2b_d0", rcv_q[0].d, 8'h55);
      chk("b2b_d1", rcv_q[1].d, 8'hA3);
    end

    // reset in the middle of data bit 4
    clear_q();
    b = 8'($urandom);
    bit16(1'b0);
    for (int i = 0; i < 4; i++) bit16(b[i]);
    bus16.rx = b[4];
    tick(3);
    rstn = 1'b0;
    tick(2);
    chk("mid_rst_busy", bus16.busy, 1'b0);
    chk("mid_rst_data", bus16.data, 8'h00);
    bus16.rx = 1'b0;
    rstn = 1'b1;
    clear_q();
    tick(30);
    chk("mid_low_busy_n", busy_q.size(), 0);
    bus16.rx = 1'b1;
    tick(4);
    send16(8'hC3, 1'b1, t0);
    tick(5);
    expect_one("c3", t0, 8'hC3);

    // short start glitch
    clear_q();
    t0 = cyc;
    bus16.rx = 1'b0;
    tick(5);
    bus16.rx = 1'b1;
    tick(20);
    chk("gl_busy_n", busy_q.size(), 2);
    if (busy_q.size() >= 2) begin
      chk("gl_busy_rise", busy_q[0].cyc, t0 + 3);
      chk("gl_busy_fall", busy_q[1].cyc, t0 + 3 + HS);
    end
    chk("gl_rcv_n", rcv_q.size(), 0);
    chk("gl_ferr_n", ferr_q.size(), 0);
    clear_q();
    send16(8'h00, 1'b1, t0);
    tick(5);
    expect_one("gl_zero", t0, 8'h00);

    // random bytes with random idle gaps (including none)
    clear_q();
    for (int k = 0; k < 6; k++) begin
      int gap;
      gap = $urandom_range(0, 12);
      if (gap > 0) tick(gap);
      b = 8'($urandom);
      send16(b, 1'b1, t0);
      exp_q.push_back('{t0 + LAT, b});
    end
    tick(5);
    chk("rnd_rcv_n", rcv_q.size(), exp_q.size());
    chk("rnd_ferr_n", ferr_q.size(), 0);
    for (int k = 0; k < exp_q.size() && k < rcv_q.size(); k++) begin
      chk("rnd_cyc", rcv_q[k].cyc, exp_q[k].cyc);
      chk("rnd_data", rcv_q[k].d, exp_q[k].d);
    end
    chk("pulse_rules", bad_pulse, 0);

    // default divisor fed by a periodic "C" transmitter
    for (int k = 0; k < 3; k++) begin
      send104(8'h43);
      tick(MD);
    end
    chk("m104_rcv_n", n104, 3);
    chk("m104_bad_data", bad104, 0);
    chk("m104_ferr", f104, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
